// File: rtl/serial_frame_pkg.sv
// Shared state encoding and parameter defaults for the serial frame scheduler.
package serial_frame_pkg;

  localparam int ADDR_W_DEF = 2;
  localparam int LEN_W_DEF  = 4;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

endpackage

// File: rtl/serial_frame_scheduler_rr_arbiter.sv
// Round-robin pick of the first set request at or after ptr, wrapping; purely combinational.
// Zero latency; no backpressure, the caller decides when a grant is taken.
module rr_arbiter #(
  parameter int IDX_W = 2
) (
  input  logic [(2**IDX_W)-1:0] req,
  input  logic [IDX_W-1:0]      ptr,
  output logic [(2**IDX_W)-1:0] gnt,
  output logic [IDX_W-1:0]      idx,
  output logic                  any
);

  localparam int N = 2**IDX_W;

  logic [IDX_W-1:0] cand;

  // N is a power of two, so the IDX_W-bit add wraps the search for free
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr + IDX_W'(i);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/serial_frame_scheduler.sv
// Round-robin serial frame transmitter: start, addr, len, len data bits, [parity], stop; one bit per clkEn.
// Outputs registered (1 clk after a clkEn edge); no backpressure. SERIAL_FRAME_PARITY_EN adds a parity bit.
module serial_frame_scheduler
  import serial_frame_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clkEn,
  input  logic [(2**ADDR_W)-1:0]          req,
  input  logic [(2**ADDR_W)*LEN_W-1:0]    len,
  input  logic [(2**ADDR_W)*DATA_W-1:0]   data,
  output logic [(2**ADDR_W)-1:0]          gnt,
  output logic                            serOut,
  output logic                            serOutValid,
  output logic                            busy,
  output logic                            done
);

  localparam int NUM_REQ = 2**ADDR_W;
  localparam int SHW     = $clog2(DATA_W) + 1;

  state_t              state, state_nxt, tail_state;
  logic [ADDR_W-1:0]   ptr, ptr_nxt, addr_sr, addr_sr_nxt;
  logic [LEN_W-1:0]    len_sr, len_sr_nxt, len_q, len_q_nxt, cnt, cnt_nxt;
  logic [DATA_W-1:0]   data_sr, data_sr_nxt;
  logic                ser_q, ser_nxt, vld_q, vld_nxt, busy_q, busy_nxt, done_q, done_nxt;
  logic [NUM_REQ-1:0]  gnt_q, gnt_nxt;
  logic                tail_ser, tail_vld;
`ifdef SERIAL_FRAME_PARITY_EN
  logic                par_q, par_nxt;
`endif

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [ADDR_W-1:0]   arb_idx;
  logic                arb_any;
  logic [LEN_W-1:0]    len_sel;
  logic [DATA_W-1:0]   data_sel, data_aln;
  logic [SHW-1:0]      sh_amt;

  rr_arbiter #(.IDX_W(ADDR_W)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Left-align data[len-1:0] so the data field always leaves from the MSB
  assign len_sel  = len[arb_idx*LEN_W +: LEN_W];
  assign data_sel = data[arb_idx*DATA_W +: DATA_W];
  assign sh_amt   = SHW'(DATA_W) - SHW'(len_sel);
  assign data_aln = data_sel << sh_amt;

  always_comb begin
`ifdef SERIAL_FRAME_PARITY_EN
    tail_state = S_PARITY;
    tail_ser   = par_q;
    tail_vld   = 1'b1;
`else
    tail_state = S_STOP;
    tail_ser   = 1'b1;
    tail_vld   = 1'b0;
`endif
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    addr_sr_nxt = addr_sr;
    len_sr_nxt  = len_sr;
    len_q_nxt   = len_q;
    cnt_nxt     = cnt;
    data_sr_nxt = data_sr;
    ser_nxt     = ser_q;
    vld_nxt     = vld_q;
    gnt_nxt     = '0;
    done_nxt    = 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
    par_nxt     = par_q;
`endif
    if (clkEn) begin
      case (state)
        S_IDLE: begin
          ser_nxt = 1'b1;
          vld_nxt = 1'b0;
          if (arb_any) begin
            gnt_nxt     = arb_gnt;
            ptr_nxt     = arb_idx + ADDR_W'(1);
            addr_sr_nxt = arb_idx;
            len_sr_nxt  = len_sel;
            len_q_nxt   = len_sel;
            data_sr_nxt = data_aln;
`ifdef SERIAL_FRAME_PARITY_EN
            par_nxt     = ^{arb_idx, len_sel, data_aln};
`endif
            state_nxt   = S_START;
            ser_nxt     = 1'b0;
          end
        end
        S_START: begin
          state_nxt = S_ADDR;
          cnt_nxt   = LEN_W'(ADDR_W - 1);
          ser_nxt   = addr_sr[ADDR_W-1];
          vld_nxt   = 1'b1;
        end
        S_ADDR: begin
          if (cnt == '0) begin
            state_nxt = S_LEN;
            cnt_nxt   = LEN_W'(LEN_W - 1);
            ser_nxt   = len_sr[LEN_W-1];
          end else begin
            cnt_nxt     = cnt - LEN_W'(1);
            addr_sr_nxt = addr_sr << 1;
            ser_nxt     = addr_sr_nxt[ADDR_W-1];
          end
        end
        S_LEN: begin
          if (cnt != '0) begin
            cnt_nxt    = cnt - LEN_W'(1);
            len_sr_nxt = len_sr << 1;
            ser_nxt    = len_sr_nxt[LEN_W-1];
          end else if (len_q == '0) begin
            state_nxt = tail_state;
            ser_nxt   = tail_ser;
            vld_nxt   = tail_vld;
          end else begin
            state_nxt = S_DATA;
            cnt_nxt   = len_q - LEN_W'(1);
            ser_nxt   = data_sr[DATA_W-1];
          end
        end
        S_DATA: begin
          if (cnt == '0) begin
            state_nxt = tail_state;
            ser_nxt   = tail_ser;
            vld_nxt   = tail_vld;
          end else begin
            cnt_nxt     = cnt - LEN_W'(1);
            data_sr_nxt = data_sr << 1;
            ser_nxt     = data_sr_nxt[DATA_W-1];
          end
        end
`ifdef SERIAL_FRAME_PARITY_EN
        S_PARITY: begin
          state_nxt = S_STOP;
          ser_nxt   = 1'b1;
          vld_nxt   = 1'b0;
        end
`endif
        S_STOP: begin
          state_nxt = S_IDLE;
          ser_nxt   = 1'b1;
          vld_nxt   = 1'b0;
          done_nxt  = 1'b1;
        end
        default: begin
          state_nxt = S_IDLE;
          ser_nxt   = 1'b1;
          vld_nxt   = 1'b0;
        end
      endcase
    end
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ptr     <= '0;
      addr_sr <= '0;
      len_sr  <= '0;
      len_q   <= '0;
      cnt     <= '0;
      data_sr <= '0;
      ser_q   <= 1'b1;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gnt_q   <= '0;
`ifdef SERIAL_FRAME_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      addr_sr <= addr_sr_nxt;
      len_sr  <= len_sr_nxt;
      len_q   <= len_q_nxt;
      cnt     <= cnt_nxt;
      data_sr <= data_sr_nxt;
      ser_q   <= ser_nxt;
      vld_q   <= vld_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      gnt_q   <= gnt_nxt;
`ifdef SERIAL_FRAME_PARITY_EN
      par_q   <= par_nxt;
`endif
    end
  end

  assign gnt         = gnt_q;
  assign serOut      = ser_q;
  assign serOutValid = vld_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
